// File: rtl/dec_pkg.sv
// Shared widths and the one-hot helper for the registered 3-to-8 decoder.
package dec_pkg;

  localparam int SEL_W = 3;
  localparam int OUT_W = 8;

  function automatic logic [OUT_W-1:0] onehot_of(input logic [SEL_W-1:0] sel);
    logic [OUT_W-1:0] v;
    v      = '0;
    v[sel] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/dec3to8_core.sv
// Purely combinational one-hot decoder; polarity-neutral (active-high in and out).
module dec3to8_core
  import dec_pkg::*;
(
  input  logic             en,
  input  logic [SEL_W-1:0] sel,
  output logic [OUT_W-1:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en) onehot = onehot_of(sel);
  end

endmodule

// File: rtl/three_to_eight_dec.sv
// Registered 3-to-8 decoder (74x138 style) with configurable enable and output polarity.
module three_to_eight_dec
  import dec_pkg::*;
#(
  parameter bit EN_ACTIVE_LOW  = 1'b1,
  parameter bit OUT_ACTIVE_LOW = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             G,
  input  logic             A,
  input  logic             B,
  input  logic             C,
  output logic [OUT_W-1:0] Y
);

  // XOR with the polarity bit turns every variant into the active-high core and back.
  localparam logic [OUT_W-1:0] OUT_MASK = {OUT_W{OUT_ACTIVE_LOW}};

  logic             en;
  logic [OUT_W-1:0] decode;

  assign en = G ^ EN_ACTIVE_LOW;

  dec3to8_core u_core (
    .en     (en),
    .sel    ({C, B, A}),
    .onehot (decode)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) Y <= OUT_MASK;
    else     Y <= decode ^ OUT_MASK;
  end

endmodule

// File: tb/tb_three_to_eight_dec.sv
// Scoreboard bench: default-polarity and all-active-high decoders driven side by side.
module tb_three_to_eight_dec;

  typedef struct {
    logic [7:0] def;
    logic [7:0] alt;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       g = 1'b0, a = 1'b0, b = 1'b0, c = 1'b0;
  logic [7:0] y_def, y_alt;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  three_to_eight_dec #(.EN_ACTIVE_LOW(1'b1), .OUT_ACTIVE_LOW(1'b1)) dut_def (
    .clk(clk), .rst(rst), .G(g), .A(a), .B(b), .C(c), .Y(y_def)
  );

  three_to_eight_dec #(.EN_ACTIVE_LOW(1'b0), .OUT_ACTIVE_LOW(1'b0)) dut_alt (
    .clk(clk), .rst(rst), .G(g), .A(a), .B(b), .C(c), .Y(y_alt)
  );

  // Reference: the selected line carries weight 2**idx; active-low output is its complement in 0..255.
  function automatic logic [7:0] model(input logic gv, input int idx, input bit en_low, input bit out_low);
    int  active;
    bit  enabled;
    enabled = en_low ? (gv == 1'b0) : (gv == 1'b1);
    active  = enabled ? (2 ** idx) : 0;
    return 8'(out_low ? (255 - active) : active);
  endfunction

  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
    n_vec++;
    if (actual !== expected) begin
      n_err++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic pushExpected();
    exp_t e;
    int   idx;
    idx   = 4 * int'(c) + 2 * int'(b) + int'(a);
    e.def = model(g, idx, 1'b1, 1'b1);
    e.alt = model(g, idx, 1'b0, 1'b0);
    exp_q.push_back(e);
  endtask

  task automatic applyStimulus(input logic gv, input int idx);
    @(negedge clk);
    g = gv;
    c = idx[2];
    b = idx[1];
    a = idx[0];
    pushExpected();
  endtask

  task automatic drainQueue();
    int budget;
    budget = 20;
    while (exp_q.size() > 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    @(negedge clk);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("[TB] FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
  endtask

  // Monitor: Y is valid every cycle outside reset, so one entry is retired per edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput("sb_def", y_def, e.def);
        checkOutput("sb_alt", y_alt, e.alt);
      end
    end
  end

  initial begin
    // Async reset before any clock edge, with arbitrary inputs.
    g = 1'($urandom); a = 1'($urandom); b = 1'($urandom); c = 1'($urandom);
    #2 rst = 1'b1;
    #1;
    checkOutput("rst_async_def", y_def, 8'hFF);
    checkOutput("rst_async_alt", y_alt, 8'h00);
    repeat (2) @(negedge clk);
    checkOutput("rst_hold_def", y_def, 8'hFF);
    checkOutput("rst_hold_alt", y_alt, 8'h00);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) applyStimulus(1'b0, i);
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, i);
    drainQueue();

    // Latency: A rises between edges; Y must not move until the next edge.
    applyStimulus(1'b0, 0);
    drainQueue();
    checkOutput("lat_pre", y_def, 8'hFE);
    applyStimulus(1'b0, 1);
    #1;
    checkOutput("lat_mid", y_def, 8'hFE);
    drainQueue();
    checkOutput("lat_post", y_def, 8'hFD);

    // Mid-operation reset with code 6 latched.
    applyStimulus(1'b0, 6);
    drainQueue();
    checkOutput("pre_rst", y_def, 8'hBF);
    #2 rst = 1'b1;
    #1;
    checkOutput("mid_rst_def", y_def, 8'hFF);
    checkOutput("mid_rst_alt", y_alt, 8'h00);
    @(negedge clk);
    checkOutput("mid_rst_hold", y_def, 8'hFF);
    rst = 1'b0;
    pushExpected();
    drainQueue();
    checkOutput("post_rst", y_def, 8'hBF);

    // Active-high variant corner: G=1 code 5, then disabled.
    applyStimulus(1'b1, 5);
    applyStimulus(1'b0, 5);
    drainQueue();
    checkOutput("alt_disabled", y_alt, 8'h00);

    // Random traffic, including same-edge enable and select changes.
    for (int n = 0; n < 200; n++) applyStimulus(1'($urandom), int'($urandom_range(0, 7)));
    drainQueue();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/three_to_eight_dec.md
Name: three_to_eight_dec

Overview:
- Registered 3-to-8 line decoder with enable, modelled on the 74x138/74x139 family.
- Select code {C,B,A} drives exactly one output line active when the decoder is enabled.
- Used as a chip-select / one-hot generator in the v74x139 logic-design lab set.
- Clocked and resettable so it can sit directly in synchronous datapaths.

Parameters:
- EN_ACTIVE_LOW, 1, 1 means G=0 enables the decoder; 0 means G=1 enables it.
- OUT_ACTIVE_LOW, 1, 1 means the selected Y bit is driven 0 and all others 1; 0 means the selected bit is driven 1 and all others 0.

Ports:
- clk  input  1  system clock, rising-edge active
- rst  input  1  asynchronous, active-high reset
- G  input  1  enable; polarity set by EN_ACTIVE_LOW
- A  input  1  select bit 0 (LSB)
- B  input  1  select bit 1
- C  input  1  select bit 2 (MSB)
- Y  output  8  decoded outputs; Y[i] corresponds to code i

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Select index: idx = {C,B,A}, unsigned 0..7, with A as the LSB.
- Enabled:
  - EN_ACTIVE_LOW=1: enabled when G==0.
  - EN_ACTIVE_LOW=0: enabled when G==1.
- Next-state decode value, one-hot, before output polarity is applied:
  - Enabled: bit idx = 1, all other bits = 0.
  - Disabled: all 8 bits = 0.
- Output polarity:
  - OUT_ACTIVE_LOW=1: Y = ~decode.
  - OUT_ACTIVE_LOW=0: Y = decode.
- Y is registered and updates on the rising clk edge.
- Latency is exactly 1 cycle from an input change to the corresponding Y.
- No combinational path from inputs to Y.
- Reset:
  - While rst==1, Y is held at the all-inactive value: 8'hFF when OUT_ACTIVE_LOW=1, 8'h00 otherwise.
  - Assertion takes effect immediately, independent of clk.
  - Deassertion takes effect synchronously: the first decode is captured on the first rising edge with rst==0.
- Invariants:
  - At most one Y bit is active at any time.
  - Exactly one Y bit is active when the enable was asserted on the previous edge.
  - Zero Y bits are active when disabled or in reset.
- Mid-operation behaviour:
  - Reset asserted mid-operation forces the inactive value immediately.
  - An enable change and a select change on the same edge are both reflected on the next cycle; no glitch on Y between edges.
- X/Z on the inputs is not required to be handled; the inputs are assumed driven.

Decomposition:
- Shared package dec_pkg:
  - SEL_W=3
  - OUT_W=8
  - a function returning the one-hot vector for a select index
- Sub-module dec3to8_core: purely combinational one-hot decoder with inputs en, sel[2:0] and output onehot[7:0].
- The top level applies the enable/output polarity parameters and the async-reset output register around dec3to8_core.

Test Plan (default parameters EN_ACTIVE_LOW=1, OUT_ACTIVE_LOW=1):
- Reset: assert rst with arbitrary inputs -> Y==8'hFF immediately, without waiting for a clk edge; it stays 8'hFF for the whole reset.
- Enabled sweep: G=0, step {C,B,A} through 0..7, one code per cycle:
  - Code 0 -> Y==8'hFE on the next cycle.
  - Code 1 (A=1) -> Y==8'hFD on the next cycle.
  - Code 7 -> Y==8'h7F on the next cycle.
  - Every code -> exactly one zero bit, at position idx.
- Disabled sweep: G=1 with all 8 codes -> Y==8'hFF every cycle.
- Latency: change A from 0 to 1 mid-cycle with G=0 -> Y stays 8'hFE until the next rising edge, then becomes 8'hFD.
- Mid-operation reset: with Y==8'hBF (code 6), assert rst between edges -> Y==8'hFF without a clk edge. Deassert rst -> the first edge yields 8'hBF again.
- Parameter variant EN_ACTIVE_LOW=0, OUT_ACTIVE_LOW=0:
  - G=1, code 5 -> Y==8'h20.
  - G=0 -> Y==8'h00.
  - Reset -> Y==8'h00.
